jt12_op_seq: RTL
================

JT12_OP_SEQ -- requirements
Module: jt12_op_seq

Interface
REQ-001 Parameter: num_ch, default 6, number of channels per frame; only 3 or 6 are legal.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous reset, active-low.
REQ-004 clk_en  in  1  slot-rate enable; state advances only when high.
REQ-005 run  in  1  1 = sequence slots; 0 = park at slot 0.
REQ-006 cfg_valid  in  1  config request; cfg_ready  out  1  accept; transfer when both high on a clk_en cycle.
REQ-007 cfg_ch  in  3  target channel; cfg_alg  in  3  algorithm 0-7; cfg_fb  in  3  feedback 0-7.
REQ-008 s1_enters/s2_enters/s3_enters/s4_enters  out  1 each  one-hot slot-group strobe.
REQ-009 cur_ch  out  3  channel of the current slot.
REQ-010 xuse_prevprev1/xuse_prev2/xuse_internal/yuse_prev1/yuse_prev2/yuse_internal  out  1 each  operator modulation-input selects.
REQ-011 fb_II  out  3  feedback of the channel, one slot after its S1 strobe.
REQ-012 zero  out  1  frame-start pulse.

Function
REQ-013 Frame = 4*num_ch slots; slot = g*num_ch + ch; group g order S1,S3,S2,S4; ch 0..num_ch-1.
REQ-014 Slot counter SHALL advance by 1 per clk_en cycle with run=1 and wrap from 4*num_ch-1 to 0.
REQ-015 run=0 SHALL reset the counter to 0 on the next clk_en and drive all strobes, selects and zero to 0.
REQ-016 All outputs SHALL be registered and describe the slot held by the counter in the same cycle.
REQ-017 zero SHALL be 1 only during slot 0 with run=1.
REQ-018 S1 slots SHALL select xuse_prevprev1=1 and yuse_prev1=1 for every algorithm.
REQ-019 S3 slots SHALL select yuse_internal=1 for alg 0,3,4,5,6; otherwise all selects 0.
REQ-020 S2 slots SHALL select xuse_internal=1 for alg 0,1,2 and yuse_prev1=1 for alg 1,5.
REQ-021 S4 slots SHALL select xuse_internal=1 for alg 0,1,2,3,4, yuse_prev1=1 for alg 2,5, and yuse_prev2=1 for alg 3.
REQ-022 Any select not named in REQ-018..021 SHALL be 0.
REQ-023 fb_II SHALL equal the fb of the channel whose S1 slot was presented on the previous clk_en cycle; otherwise it holds its last value.
REQ-024 Per-channel alg/fb table SHALL be num_ch x 6 bits.
REQ-025 An accepted config write SHALL go into a one-entry pending buffer and drive cfg_ready low.
REQ-026 Pending write SHALL commit on the clk_en cycle presenting slot 4*num_ch-1, or on the next clk_en when run=0; cfg_ready SHALL return high the following cycle.
REQ-027 Algorithm and feedback SHALL NOT change within a frame for any channel.
REQ-028 A write with cfg_ch >= num_ch SHALL be accepted and discarded at commit, leaving the table unchanged.
REQ-029 clk_en=0 SHALL freeze all state and outputs, including a pending commit.

Reset
REQ-030 While rst=0: counter=0, table=0, pending buffer empty, cfg_ready=1, all other outputs 0.
REQ-031 rst asserted mid-frame SHALL discard any pending write; the first slot after release SHALL be slot 0.

Structure
REQ-032 Package jt12_op_seq_pkg SHALL hold slot-group encoding (S1=0,S3=1,S2=2,S4=3), frame-length function of num_ch, and the select-table constants.
REQ-033 Algorithm/slot decode SHALL be one combinational sub-module, jt12_alg_dec (inputs: group, alg; outputs: six selects).

Verification
REQ-034 Reset release, run=1, num_ch=6 -> zero at slot 0 only; strobes s1 x6, s3 x6, s2 x6, s4 x6; cur_ch 0..5 in each group; repeats every 24 clk_en.
REQ-035 Ch2 alg=3, fb=5, then run -> ch2 S4 slot gives xuse_internal=1, yuse_prev2=1; fb_II=5 one slot after ch2 S1.
REQ-036 Write ch0 alg=7 at slot 5 -> cfg_ready=0 until slot 23; ch0 S3 in the current frame still uses old alg; next frame ch0 S3/S2/S4 selects all 0.
REQ-037 clk_en low 3 cycles mid-frame -> outputs frozen; sequence resumes at the same slot.
REQ-038 Write cfg_ch=6 -> accepted, table unchanged after commit; cfg_ready high again after frame end.
REQ-039 rst low at slot 10 with a write pending -> table unchanged, cfg_ready=1; after release first strobe is s1_enters with cur_ch=0.

Source files
------------

// File: rtl/jt12_op_seq_pkg.sv
// Shared types and constants for the operator slot sequencer.
// Slot groups follow the order in which operators are visited within a frame.
package jt12_op_seq_pkg;

  typedef enum logic [1:0] {
    grp_s1 = 2'd0,
    grp_s3 = 2'd1,
    grp_s2 = 2'd2,
    grp_s4 = 2'd3
  } grp_e;

  // One bit per algorithm (bit n = alg n) for each non-trivial select.
  localparam logic [7:0] s3_yint_alg = 8'b0111_1001;
  localparam logic [7:0] s2_xint_alg = 8'b0000_0111;
  localparam logic [7:0] s2_yp1_alg  = 8'b0010_0010;
  localparam logic [7:0] s4_xint_alg = 8'b0001_1111;
  localparam logic [7:0] s4_yp1_alg  = 8'b0010_0100;
  localparam logic [7:0] s4_yp2_alg  = 8'b0000_1000;

  function automatic int frame_len(input int num_ch);
    return 4 * num_ch;
  endfunction

endpackage

// File: rtl/jt12_alg_dec.sv
// Combinational decode of slot group and algorithm into operator modulation-input selects.
module jt12_alg_dec
  import jt12_op_seq_pkg::*;
(
  input  grp_e       grp,
  input  logic [2:0] alg,
  output logic       xuse_prevprev1,
  output logic       xuse_prev2,
  output logic       xuse_internal,
  output logic       yuse_prev1,
  output logic       yuse_prev2,
  output logic       yuse_internal
);

  always_comb begin
    xuse_prevprev1 = 1'b0;
    xuse_prev2     = 1'b0;
    xuse_internal  = 1'b0;
    yuse_prev1     = 1'b0;
    yuse_prev2     = 1'b0;
    yuse_internal  = 1'b0;
    case (grp)
      grp_s1: begin
        xuse_prevprev1 = 1'b1;
        yuse_prev1     = 1'b1;
      end
      grp_s3: yuse_internal = s3_yint_alg[alg];
      grp_s2: begin
        xuse_internal = s2_xint_alg[alg];
        yuse_prev1    = s2_yp1_alg[alg];
      end
      grp_s4: begin
        xuse_internal = s4_xint_alg[alg];
        yuse_prev1    = s4_yp1_alg[alg];
        yuse_prev2    = s4_yp2_alg[alg];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/jt12_op_seq.sv
// Operator slot sequencer: walks S1,S3,S2,S4 groups per channel, presents registered
// modulation selects and feedback, and applies config writes only at frame boundaries.
module jt12_op_seq
  import jt12_op_seq_pkg::*;
#(
  parameter int num_ch = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       run,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_ch,
  input  logic [2:0] cfg_alg,
  input  logic [2:0] cfg_fb,
  output logic       s1_enters,
  output logic       s2_enters,
  output logic       s3_enters,
  output logic       s4_enters,
  output logic [2:0] cur_ch,
  output logic       xuse_prevprev1,
  output logic       xuse_prev2,
  output logic       xuse_internal,
  output logic       yuse_prev1,
  output logic       yuse_prev2,
  output logic       yuse_internal,
  output logic [2:0] fb_II,
  output logic       zero
);

  if (num_ch != 3 && num_ch != 6) begin : g_bad_num_ch
    $error("jt12_op_seq: num_ch must be 3 or 6");
  end

  localparam logic [4:0] last_slot = 5'(frame_len(num_ch) - 1);
  localparam logic [2:0] last_ch   = 3'(num_ch - 1);

  logic [4:0] slot, nxt_slot;
  logic [1:0] grp, nxt_grp;
  logic [2:0] ch, nxt_ch;
  logic       active;
  logic [5:0] tbl [num_ch];
  logic [2:0] pend_ch, pend_alg, pend_fb;
  logic [2:0] nxt_alg, cur_fb;
  logic       d_xpp1, d_xp2, d_xint, d_yp1, d_yp2, d_yint;
  logic       commit;

  // A parked sequencer restarts at slot 0 rather than advancing past it.
  always_comb begin
    nxt_slot = slot + 5'd1;
    nxt_grp  = grp;
    nxt_ch   = ch + 3'd1;
    if (!active || slot == last_slot) begin
      nxt_slot = '0;
      nxt_grp  = '0;
      nxt_ch   = '0;
    end else if (ch == last_ch) begin
      nxt_ch  = '0;
      nxt_grp = grp + 2'd1;
    end
  end

  always_comb begin
    nxt_alg = '0;
    cur_fb  = '0;
    for (int i = 0; i < num_ch; i++) begin
      if (nxt_ch == 3'(i)) nxt_alg = tbl[i][5:3];
      if (ch == 3'(i))     cur_fb  = tbl[i][2:0];
    end
  end

  jt12_alg_dec u_dec (
    .grp            (grp_e'(nxt_grp)),
    .alg            (nxt_alg),
    .xuse_prevprev1 (d_xpp1),
    .xuse_prev2     (d_xp2),
    .xuse_internal  (d_xint),
    .yuse_prev1     (d_yp1),
    .yuse_prev2     (d_yp2),
    .yuse_internal  (d_yint)
  );

  // cfg_ready low doubles as the pending-buffer-full flag.
  assign commit = !cfg_ready && (!run || (active && slot == last_slot));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot           <= '0;
      grp            <= '0;
      ch             <= '0;
      active         <= 1'b0;
      for (int i = 0; i < num_ch; i++) tbl[i] <= '0;
      pend_ch        <= '0;
      pend_alg       <= '0;
      pend_fb        <= '0;
      cfg_ready      <= 1'b1;
      s1_enters      <= 1'b0;
      s2_enters      <= 1'b0;
      s3_enters      <= 1'b0;
      s4_enters      <= 1'b0;
      cur_ch         <= '0;
      xuse_prevprev1 <= 1'b0;
      xuse_prev2     <= 1'b0;
      xuse_internal  <= 1'b0;
      yuse_prev1     <= 1'b0;
      yuse_prev2     <= 1'b0;
      yuse_internal  <= 1'b0;
      fb_II          <= '0;
      zero           <= 1'b0;
    end else if (clk_en) begin
      if (!run) begin
        slot           <= '0;
        grp            <= '0;
        ch             <= '0;
        active         <= 1'b0;
        s1_enters      <= 1'b0;
        s2_enters      <= 1'b0;
        s3_enters      <= 1'b0;
        s4_enters      <= 1'b0;
        cur_ch         <= '0;
        xuse_prevprev1 <= 1'b0;
        xuse_prev2     <= 1'b0;
        xuse_internal  <= 1'b0;
        yuse_prev1     <= 1'b0;
        yuse_prev2     <= 1'b0;
        yuse_internal  <= 1'b0;
        zero           <= 1'b0;
      end else begin
        slot           <= nxt_slot;
        grp            <= nxt_grp;
        ch             <= nxt_ch;
        active         <= 1'b1;
        s1_enters      <= (nxt_grp == grp_s1);
        s2_enters      <= (nxt_grp == grp_s2);
        s3_enters      <= (nxt_grp == grp_s3);
        s4_enters      <= (nxt_grp == grp_s4);
        cur_ch         <= nxt_ch;
        xuse_prevprev1 <= d_xpp1;
        xuse_prev2     <= d_xp2;
        xuse_internal  <= d_xint;
        yuse_prev1     <= d_yp1;
        yuse_prev2     <= d_yp2;
        yuse_internal  <= d_yint;
        zero           <= (nxt_slot == 5'd0);
      end

      if (active && grp == grp_s1) fb_II <= cur_fb;

      if (commit) begin
        for (int i = 0; i < num_ch; i++)
          if (pend_ch == 3'(i)) tbl[i] <= {pend_alg, pend_fb};
        cfg_ready <= 1'b1;
      end else if (cfg_valid && cfg_ready) begin
        pend_ch   <= cfg_ch;
        pend_alg  <= cfg_alg;
        pend_fb   <= cfg_fb;
        cfg_ready <= 1'b0;
      end
    end
  end

endmodule
